atmega_pcint: RTL and testbench
===============================

Name: atmega_pcint

Overview:
- Input-side stage sitting directly upstream of the PIO block.
- Takes raw, asynchronous pad levels and synchronises them, producing the `io_in` vector the PIO samples through its PIN register.
- Also implements the ATmega pin-change interrupt group for one port: PCMSK mask, PCIE enable bit in PCICR, PCIF flag bit in PCIFR.
- Raises an interrupt request to the CPU core's vector logic.

Parameters:
- BUS_ADDR_DATA_LEN, 8: I/O bus address width.
- PORT_WIDTH, 8: number of monitored pins.
- PCICR_ADDR, 'h68: address of the PCICR register.
- PCIFR_ADDR, 'h3B: address of the PCIFR register.
- PCMSK_ADDR, 'h6B: address of this group's PCMSK register.
- PCINT_BIT, 0: bit position of this group inside PCICR/PCIFR (0..7).
- SYNC_STAGES, 2: synchroniser depth, minimum 2.
- FILTER_CYCLES, 4: stable cycles required when the glitch filter is compiled in (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- addr_dat  in  BUS_ADDR_DATA_LEN  I/O address.
- wr_dat  in  1  write strobe, one cycle.
- rd_dat  in  1  read strobe.
- bus_dat_in  in  8  write data.
- bus_dat_out  out  8  read data (combinational).
- pad_in  in  PORT_WIDTH  raw asynchronous pad levels.
- pin_out  out  PORT_WIDTH  synchronised (and filtered) pin levels; drives the PIO `io_in`.
- int_req  out  1  pin-change interrupt request.
- int_ack  in  1  one-cycle vector-taken acknowledge from the core.

Behaviour:
- Reset (async, rst=1):
  - Synchroniser flops, pin_out, prev-level register, PCMSK, PCIE and PCIF all go to 0.
  - int_req=0 and bus_dat_out=0.
- Synchroniser:
  - Each pad bit passes through SYNC_STAGES flops.
  - pin_out = last stage, so latency from a pad edge to pin_out is SYNC_STAGES clocks.
- Change detect:
  - change = |((pin_out ^ prev) & PCMSK).
  - prev <= pin_out every cycle.
  - A masked pin toggle therefore sets PCIF one cycle after pin_out changes.
  - Detection is independent of PCIE: the flag sets even when the group is disabled, as on silicon.
- Flag rules, evaluated in this priority order each clock:
  1. If change=1, PCIF <= 1. Set wins over any clear in the same cycle, so no event is lost.
  2. Else if int_ack, PCIF <= 0.
  3. Else if wr_dat at PCIFR_ADDR and bus_dat_in[PCINT_BIT]=1, PCIF <= 0 (write-one-to-clear). Writing 0 has no effect.
- int_req = PCIF & PCIE, registered-free (combinational from the flops).
  - Clearing PCIE masks the request but keeps the flag.
  - Setting PCIE later with PCIF=1 raises int_req immediately.
- Register writes (wr_dat):
  - PCMSK_ADDR: PCMSK <= bus_dat_in[PORT_WIDTH-1:0].
  - PCICR_ADDR: PCIE <= bus_dat_in[PCINT_BIT]; all other bits are ignored.
- Reads (rd_dat & ~rst), otherwise bus_dat_out=0:
  - PCMSK_ADDR returns PCMSK.
  - PCICR_ADDR returns PCIE at bit PCINT_BIT, zeros elsewhere.
  - PCIFR_ADDR returns PCIF at bit PCINT_BIT, zeros elsewhere.
  - Any other address returns 0.
  - Several group instances share PCICR/PCIFR; the bus mux ORs their outputs.
- Mask change mid-run: a PCMSK write takes effect on the next cycle's compare. It does not itself create a change event.
- Reset mid-operation: a pending flag is lost and int_req drops asynchronously.

Optional Feature:
- Macro: ATMEGA_PCINT_GLITCH_FILTER_EN.
- When defined:
  - Each bit gets an 8-bit stability counter after the synchroniser.
  - pin_out[i] updates only after the synchronised value differs from pin_out[i] for FILTER_CYCLES consecutive clocks.
  - The counter restarts on any bounce.
  - Latency becomes SYNC_STAGES + FILTER_CYCLES.
- When undefined: there are no counters, and pin_out is the synchroniser output.

Decomposition:
- Shared package `atmega_pcint_pkg` holds:
  - default address constants (PCICR 'h68, PCIFR 'h3B, PCMSK0/1/2 'h6B/'h6C/'h6D);
  - SYNC_STAGES_MIN=2;
  - filter counter width constant (8).
- One natural sub-module, `atmega_pin_sync`: the per-port synchroniser plus optional filter, producing pin_out.
- Flag, register and bus logic stay in the top module.

Test Plan:
- Reset, then read PCMSK/PCICR/PCIFR → all 0x00; pin_out=0; int_req=0.
- PCMSK=0x01, PCICR=0x01; pad_in 0x00→0x01 → pin_out=0x01 after 2 clocks, PCIF=1 the next clock, int_req=1; read PCIFR=0x01.
- Toggle unmasked pad bit 3 with PCMSK=0x01 → PCIF stays 0, int_req stays 0.
- PCIF=1; write PCIFR=0x01 in the same cycle as a new masked change → PCIF remains 1. A later write of 0x01 with no change → PCIF=0, int_req=0.
- PCIE=0 with a masked toggle → PCIF=1, int_req=0. Write PCICR=0x01 → int_req=1 the next cycle; pulse int_ack → PCIF=0.
- With ATMEGA_PCINT_GLITCH_FILTER_EN and FILTER_CYCLES=4:
  - a 3-clock pad pulse → no pin_out change and no flag;
  - a 6-clock pulse → pin_out rises at SYNC_STAGES+4 clocks and PCIF is set.

Source files
------------

// File: rtl/atmega_pcint_pkg.sv
// Shared constants for the ATmega pin-change interrupt group: default register
// addresses, synchroniser minimum depth and glitch-filter counter width.
package atmega_pcint_pkg;

  localparam int BUS_ADDR_W_DEF  = 8;
  localparam int PCICR_ADDR_DEF  = 'h68;
  localparam int PCIFR_ADDR_DEF  = 'h3B;
  localparam int PCMSK0_ADDR_DEF = 'h6B;
  localparam int PCMSK1_ADDR_DEF = 'h6C;
  localparam int PCMSK2_ADDR_DEF = 'h6D;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int FILT_CNT_W      = 8;

  // Which of this group's registers the current bus address selects.
  typedef enum logic [1:0] {
    REG_NONE,
    REG_PCMSK,
    REG_PCICR,
    REG_PCIFR
  } reg_sel_e;

endpackage : atmega_pcint_pkg

// File: rtl/atmega_pcint_if.sv
// I/O bus between the core and the pin-change group: address, strobes and
// data in both directions. The core side is master, register blocks are slave.
interface atmega_pcint_if
  import atmega_pcint_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W_DEF
);
  logic [ADDR_W-1:0] addr_dat;
  logic              wr_dat;
  logic              rd_dat;
  logic [7:0]        bus_dat_in;
  logic [7:0]        bus_dat_out;

  modport master (
    output addr_dat, wr_dat, rd_dat, bus_dat_in,
    input  bus_dat_out
  );

  modport slave (
    input  addr_dat, wr_dat, rd_dat, bus_dat_in,
    output bus_dat_out
  );
endinterface : atmega_pcint_if

// File: rtl/atmega_pin_sync.sv
// Per-port pad synchroniser with an optional per-bit stability filter
// (enabled by ATMEGA_PCINT_GLITCH_FILTER_EN); produces the PIO io_in levels.
module atmega_pin_sync
  import atmega_pcint_pkg::*;
#(
  parameter int PORT_WIDTH    = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PORT_WIDTH-1:0] pad_in,
  output logic [PORT_WIDTH-1:0] pin_out
);

  localparam int L_STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  logic [L_STAGES-1:0][PORT_WIDTH-1:0] r_sync;
  logic [PORT_WIDTH-1:0]               w_sync;

  // NOTE: the synchroniser is a register chain, not a RAM, so every stage is
  // reset; a stale pre-reset level must never reach the change detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      // NOTE: non-blocking assignment makes every stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      r_sync <= {r_sync[L_STAGES-2:0], pad_in};
    end
  end

  assign w_sync = r_sync[L_STAGES-1];

`ifdef ATMEGA_PCINT_GLITCH_FILTER_EN
  localparam logic [FILT_CNT_W-1:0] L_LAST = FILT_CNT_W'(FILTER_CYCLES - 1);

  logic [FILT_CNT_W-1:0] r_cnt [PORT_WIDTH];
  logic [PORT_WIDTH-1:0] r_pin;

  // A bit follows the synchronised level only after it has disagreed with the
  // current output for FILTER_CYCLES clocks in a row; any bounce restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pin <= '0;
      for (int i = 0; i < PORT_WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < PORT_WIDTH; i++) begin
        if (w_sync[i] == r_pin[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == L_LAST) begin
          r_pin[i] <= w_sync[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign pin_out = r_pin;
`else
  assign pin_out = w_sync;
`endif

endmodule : atmega_pin_sync

// File: rtl/atmega_pcint.sv
// ATmega pin-change interrupt group for one port: synchronised pin levels,
// PCMSK/PCIE/PCIF registers and the interrupt request.
// Optional glitch filter: define ATMEGA_PCINT_GLITCH_FILTER_EN.
module atmega_pcint
  import atmega_pcint_pkg::*;
#(
  parameter int BUS_ADDR_DATA_LEN = BUS_ADDR_W_DEF,
  parameter int PORT_WIDTH        = 8,
  parameter int PCICR_ADDR        = PCICR_ADDR_DEF,
  parameter int PCIFR_ADDR        = PCIFR_ADDR_DEF,
  parameter int PCMSK_ADDR        = PCMSK0_ADDR_DEF,
  parameter int PCINT_BIT         = 0,
  parameter int SYNC_STAGES       = 2,
  parameter int FILTER_CYCLES     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  atmega_pcint_if.slave         bus,
  input  logic [PORT_WIDTH-1:0] pad_in,
  output logic [PORT_WIDTH-1:0] pin_out,
  output logic                  int_req,
  input  logic                  int_ack
);

  localparam logic [BUS_ADDR_DATA_LEN-1:0] L_PCICR = BUS_ADDR_DATA_LEN'(PCICR_ADDR);
  localparam logic [BUS_ADDR_DATA_LEN-1:0] L_PCIFR = BUS_ADDR_DATA_LEN'(PCIFR_ADDR);
  localparam logic [BUS_ADDR_DATA_LEN-1:0] L_PCMSK = BUS_ADDR_DATA_LEN'(PCMSK_ADDR);

  logic [PORT_WIDTH-1:0] w_pin;
  logic [PORT_WIDTH-1:0] r_prev;
  logic [PORT_WIDTH-1:0] r_pcmsk;
  logic                  r_pcie;
  logic                  r_pcif;
  reg_sel_e              w_sel;
  logic                  w_change;
  logic                  w_pcif_w1c;
  logic [7:0]            w_dat_out;

  atmega_pin_sync #(
    .PORT_WIDTH    (PORT_WIDTH),
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .pad_in  (pad_in),
    .pin_out (w_pin)
  );

  // NOTE: every always_comb output gets a default before any branch so an
  // unmatched address can never infer a latch.
  always_comb begin
    w_sel = REG_NONE;
    if (bus.addr_dat == L_PCMSK)      w_sel = REG_PCMSK;
    else if (bus.addr_dat == L_PCICR) w_sel = REG_PCICR;
    else if (bus.addr_dat == L_PCIFR) w_sel = REG_PCIFR;
  end

  assign w_change   = |((w_pin ^ r_prev) & r_pcmsk);
  assign w_pcif_w1c = bus.wr_dat && (w_sel == REG_PCIFR) && bus.bus_dat_in[PCINT_BIT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= '0;
      r_pcmsk <= '0;
      r_pcie  <= 1'b0;
      r_pcif  <= 1'b0;
    end else begin
      r_prev <= w_pin;
      if (bus.wr_dat && (w_sel == REG_PCMSK)) r_pcmsk <= bus.bus_dat_in[PORT_WIDTH-1:0];
      if (bus.wr_dat && (w_sel == REG_PCICR)) r_pcie  <= bus.bus_dat_in[PCINT_BIT];
      // Set beats both clears so an edge landing on an ack or W1C is kept.
      if (w_change)        r_pcif <= 1'b1;
      else if (int_ack)    r_pcif <= 1'b0;
      else if (w_pcif_w1c) r_pcif <= 1'b0;
    end
  end

  // Shared PCICR/PCIFR bits from other groups are ORed in by the bus mux.
  always_comb begin
    w_dat_out = '0;
    if (bus.rd_dat && !rst) begin
      unique case (w_sel)
        REG_PCMSK: w_dat_out[PORT_WIDTH-1:0] = r_pcmsk;
        REG_PCICR: w_dat_out[PCINT_BIT]      = r_pcie;
        REG_PCIFR: w_dat_out[PCINT_BIT]      = r_pcif;
        default:   w_dat_out                 = '0;
      endcase
    end
  end

  assign bus.bus_dat_out = w_dat_out;
  assign pin_out         = w_pin;
  assign int_req         = r_pcif & r_pcie;

endmodule : atmega_pcint

// File: tb/tb_atmega_pcint.sv
// Self-checking bench for atmega_pcint: a cycle-level reference model of the
// pin pipeline and flag rules, checked every cycle, plus directed expectations.
module tb_atmega_pcint;

  localparam int SYNC = 2;
  localparam int FILT = 4;
`ifdef ATMEGA_PCINT_GLITCH_FILTER_EN
  localparam int LAT = SYNC + FILT;
`else
  localparam int LAT = SYNC;
`endif
  localparam int HD = SYNC + FILT + 1;

  localparam logic [7:0] A_PCICR = 8'h68;
  localparam logic [7:0] A_PCIFR = 8'h3B;
  localparam logic [7:0] A_PCMSK = 8'h6B;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pad_in = '0;
  logic [7:0] pin_out;
  logic       int_req;
  logic       int_ack = 1'b0;

  atmega_pcint_if #(.ADDR_W(8)) bus_if ();

  atmega_pcint #(
    .BUS_ADDR_DATA_LEN (8),
    .PORT_WIDTH        (8),
    .PCICR_ADDR        ('h68),
    .PCIFR_ADDR        ('h3B),
    .PCMSK_ADDR        ('h6B),
    .PCINT_BIT         (0),
    .SYNC_STAGES       (SYNC),
    .FILTER_CYCLES     (FILT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .pad_in  (pad_in),
    .pin_out (pin_out),
    .int_req (int_req),
    .int_ack (int_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pin level = pad history delayed by SYNC clocks; with the filter, a bit
  // flips only once the last FILT delayed samples all disagree with it.
  logic [7:0] m_hist [HD];
  logic [7:0] m_pin, m_pin_prev, m_msk;
  logic       m_pcie, m_pcif;

  always @(posedge clk or posedge rst) begin : model
    logic [7:0] nh [HD];
    logic [7:0] np;
    logic       edge_seen;
    if (rst) begin
      for (int k = 0; k < HD; k++) m_hist[k] <= '0;
      m_pin <= '0; m_pin_prev <= '0; m_msk <= '0; m_pcie <= 1'b0; m_pcif <= 1'b0;
    end else begin
      nh[0] = pad_in;
      for (int k = 1; k < HD; k++) nh[k] = m_hist[k-1];
`ifdef ATMEGA_PCINT_GLITCH_FILTER_EN
      np = m_pin;
      for (int b = 0; b < 8; b++) begin
        logic all_diff;
        all_diff = 1'b1;
        for (int k = 0; k < FILT; k++) if (nh[SYNC+k][b] == m_pin[b]) all_diff = 1'b0;
        if (all_diff) np[b] = ~m_pin[b];
      end
`else
      np = nh[SYNC-1];
`endif
      edge_seen = ((m_pin ^ m_pin_prev) & m_msk) != 0;
      for (int k = 0; k < HD; k++) m_hist[k] <= nh[k];
      m_pin      <= np;
      m_pin_prev <= m_pin;
      if (bus_if.wr_dat && bus_if.addr_dat == A_PCMSK) m_msk  <= bus_if.bus_dat_in;
      if (bus_if.wr_dat && bus_if.addr_dat == A_PCICR) m_pcie <= bus_if.bus_dat_in[0];
      if (edge_seen) m_pcif <= 1'b1;
      else if (int_ack) m_pcif <= 1'b0;
      else if (bus_if.wr_dat && bus_if.addr_dat == A_PCIFR && bus_if.bus_dat_in[0]) m_pcif <= 1'b0;
    end
  end

  function automatic logic [7:0] model_read();
    if (!bus_if.rd_dat || rst) return 8'h00;
    case (bus_if.addr_dat)
      A_PCMSK: return m_msk;
      A_PCICR: return {7'b0, m_pcie};
      A_PCIFR: return {7'b0, m_pcif};
      default: return 8'h00;
    endcase
  endfunction

  always @(negedge clk) begin : compare
    check("pin_out", pin_out, m_pin);
    check("int_req", int_req, m_pcif & m_pcie);
    if (bus_if.rd_dat) check("bus_dat_out", bus_if.bus_dat_out, model_read());
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus_if.addr_dat = a; bus_if.bus_dat_in = d; bus_if.wr_dat = 1'b1;
    tick();
    bus_if.wr_dat = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input logic [7:0] exp);
    bus_if.addr_dat = a; bus_if.rd_dat = 1'b1;
    @(negedge clk);
    #1;
    check(name, bus_if.bus_dat_out, exp);
    bus_if.rd_dat = 1'b0;
  endtask

  initial begin
    bus_if.addr_dat = '0; bus_if.wr_dat = 1'b0; bus_if.rd_dat = 1'b0; bus_if.bus_dat_in = '0;
    tick(3);
    rst = 1'b0;
    tick();

    // Reset state
    read_check("rst_pcmsk", A_PCMSK, 8'h00);
    read_check("rst_pcicr", A_PCICR, 8'h00);
    read_check("rst_pcifr", A_PCIFR, 8'h00);
    check("rst_pin", pin_out, 8'h00);
    check("rst_int", int_req, 1'b0);

    // Masked rise: pin after LAT clocks, flag one clock later
    bus_write(A_PCMSK, 8'h01);
    bus_write(A_PCICR, 8'h01);
    pad_in = 8'h01;
    tick(LAT - 1);
    check("lat_pin_early", pin_out, 8'h00);
    tick();
    check("lat_pin", pin_out, 8'h01);
    check("lat_int_early", int_req, 1'b0);
    tick();
    check("flag_int", int_req, 1'b1);
    read_check("flag_pcifr", A_PCIFR, 8'h01);

    // Clear, then toggle an unmasked bit
    bus_write(A_PCIFR, 8'h01);
    check("w1c_int", int_req, 1'b0);
    pad_in = 8'h09;
    tick(LAT + 2);
    check("unmasked_pin", pin_out, 8'h09);
    check("unmasked_int", int_req, 1'b0);
    read_check("unmasked_pcifr", A_PCIFR, 8'h00);

    // W1C in the same cycle as a new change: set wins
    pad_in = 8'h08;
    tick(LAT + 1);
    check("set_again", int_req, 1'b1);
    pad_in = 8'h09;
    tick(LAT);
    bus_write(A_PCIFR, 8'h01);
    check("set_beats_w1c", int_req, 1'b1);
    bus_write(A_PCIFR, 8'h01);
    check("w1c_later", int_req, 1'b0);
    read_check("w1c_pcifr", A_PCIFR, 8'h00);

    // Group disabled: flag sets, request masked; enable raises it; ack clears
    bus_write(A_PCICR, 8'h00);
    pad_in = 8'h08;
    tick(LAT + 1);
    read_check("dis_pcifr", A_PCIFR, 8'h01);
    check("dis_int", int_req, 1'b0);
    bus_write(A_PCICR, 8'h01);
    check("en_int", int_req, 1'b1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("ack_int", int_req, 1'b0);
    read_check("ack_pcifr", A_PCIFR, 8'h00);

    // PCICR ignores other bits; writing 0 to PCIFR keeps the flag
    bus_write(A_PCICR, 8'hFE);
    read_check("pcicr_fe", A_PCICR, 8'h00);
    bus_write(A_PCICR, 8'hFF);
    read_check("pcicr_ff", A_PCICR, 8'h01);
    pad_in = 8'h09;
    tick(LAT + 1);
    bus_write(A_PCIFR, 8'h00);
    read_check("w0_pcifr", A_PCIFR, 8'h01);
    int_ack = 1'b1; tick(); int_ack = 1'b0;

    // Mask change alone creates no event; unknown address reads 0
    bus_write(A_PCMSK, 8'hFF);
    tick(3);
    read_check("msk_pcmsk", A_PCMSK, 8'hFF);
    read_check("msk_pcifr", A_PCIFR, 8'h00);
    read_check("other_addr", 8'h10, 8'h00);

    // Change in the same cycle as ack: set wins
    pad_in = 8'h0B;
    tick(LAT);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("set_beats_ack", int_req, 1'b1);

    // Asynchronous reset mid-operation drops the request immediately
    #2 rst = 1'b1;
    #1 check("async_rst_int", int_req, 1'b0);
    check("async_rst_pin", pin_out, 8'h00);
    tick(2);
    rst = 1'b0;
    tick(LAT + 2);
    check("post_rst_pin", pin_out, 8'h0B);
    read_check("post_rst_pcifr", A_PCIFR, 8'h00);

`ifdef ATMEGA_PCINT_GLITCH_FILTER_EN
    bus_write(A_PCMSK, 8'h01);
    bus_write(A_PCICR, 8'h01);
    // 3-clock glitch is swallowed
    pad_in = 8'h0A; tick(3); pad_in = 8'h0B;
    tick(12);
    check("glitch_pin", pin_out, 8'h0B);
    read_check("glitch_pcifr", A_PCIFR, 8'h00);
    // 6-clock pulse passes after SYNC+FILT clocks
    pad_in = 8'h0A;
    tick(LAT - 1);
    check("pulse_pin_early", pin_out, 8'h0B);
    tick();
    check("pulse_pin", pin_out, 8'h0A);
    pad_in = 8'h0B;
    tick();
    check("pulse_int", int_req, 1'b1);
    tick(LAT + 4);
`endif

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_atmega_pcint
